// File: rtl/fxp_div_ctrl.sv
// Unsigned fixed-point divider: start/done sequencer around a restoring shift-subtract loop.
// Optional build macro FXP_DIV_ROUND_EN adds a round-half-up state after the loop.
module fxp_div_ctrl #(
  parameter int N = 10,
  parameter int F = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] rem,
  output logic         ovf,
  output logic         dz
);

  localparam int W = N + F;
  localparam logic [3:0] CNT_INIT = 4'(16 - W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_ROUND,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] rem_q, rem_d;
  logic         ovf_q, ovf_d;
  logic         dz_q, dz_d;

  // Working datapath; the partial remainder stays below B, so N bits hold it.
  logic [W-1:0] d_q, d_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] r_q, r_d;

  logic [N:0]   t;
  logic         ge;
  logic [N-1:0] diff;
  logic [W-1:0] d_shift;
  logic [4:0]   cnt_inc;

`ifdef FXP_DIV_ROUND_EN
  logic [N:0]   rnd;

  // Returns {ovf, q} after round-half-up; saturates when the increment carries out.
  function automatic logic [N:0] round_q(input logic [N-1:0] q_in, input logic ovf_in,
                                         input logic [N-1:0] r_in, input logic [N-1:0] b_in);
    logic [N:0] r2;
    logic [N:0] inc;
    r2  = {r_in, 1'b0};
    inc = {1'b0, q_in} + {{N{1'b0}}, 1'b1};
    if (ovf_in || (r2 < {1'b0, b_in}))
      round_q = {ovf_in, q_in};
    else if (inc[N])
      round_q = {1'b1, {N{1'b1}}};
    else
      round_q = {1'b0, inc[N-1:0]};
  endfunction
`endif

  always_comb begin
    t       = {r_q, d_q[W-1]};
    ge      = (t >= {1'b0, b_q});
    diff    = t[N-1:0] - b_q;
    d_shift = {d_q[W-2:0], ge};
    cnt_inc = {1'b0, cnt_q} + 5'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    d_d     = d_q;
    b_d     = b_q;
    r_d     = r_q;
`ifdef FXP_DIV_ROUND_EN
    rnd     = round_q(q_q, ovf_q, r_q, b_q);
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
            q_d     = '1;
            rem_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_INIT;
            d_d     = {a, {F{1'b0}}};
            b_d     = b;
          end
        end
      end
      S_INIT: begin
        r_d     = '0;
        cnt_d   = CNT_INIT;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        state_d = S_CALC;
      end
      S_CALC: begin
        r_d   = ge ? diff : t[N-1:0];
        d_d   = d_shift;
        cnt_d = cnt_inc[3:0];
        if (cnt_inc[4]) begin
          if (d_shift[W-1:N] != '0) begin
            ovf_d = 1'b1;
            q_d   = '1;
          end else begin
            q_d   = d_shift[N-1:0];
          end
          rem_d = r_d;
`ifdef FXP_DIV_ROUND_EN
          state_d = S_ROUND;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FXP_DIV_ROUND_EN
      S_ROUND: begin
        ovf_d   = rnd[N];
        q_d     = rnd[N-1:0];
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    d_q <= d_d;
    b_q <= b_d;
    r_q <= r_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_fxp_div_ctrl.sv
// Bench for fxp_div_ctrl: directed plan cases plus randomized operands against an arithmetic model.
module tb_fxp_div_ctrl;
  localparam int N    = 10;
  localparam int F    = 5;
  localparam int MAXQ = (1 << N) - 1;
`ifdef FXP_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT = N + F + 2 + RND;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done, ovf, dz;
  logic [N-1:0] q, rem;

  int total = 0;
  int bad   = 0;

  fxp_div_ctrl #(.N(N), .F(F)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .rem(rem), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  // Reference: quotient of (a * 2^F) / b with saturation and optional round-half-up.
  task automatic model(input int av, input int bv, output int eq, output int erem,
                       output int eovf, output int edz, output int elat);
    int num, qi, ri;
    num = av * (1 << F);
    if (bv == 0) begin
      eq = MAXQ; erem = 0; eovf = 0; edz = 1; elat = 1;
    end else begin
      qi = num / bv; ri = num % bv;
      edz = 0; erem = ri; elat = LAT;
      if (qi > MAXQ) begin
        eq = MAXQ; eovf = 1;
      end else begin
        eq = qi; eovf = 0;
        if (RND == 1 && 2 * ri >= bv) begin
          if (qi + 1 > MAXQ) begin eq = MAXQ; eovf = 1; end
          else eq = qi + 1;
        end
      end
    end
  endtask

  // Issues one division; inj_edge != 0 pulses a stray start sampled at that edge (edge 1 = accept).
  task automatic run_div(input int av, input int bv, input int inj_edge,
                         output int gq, output int grem, output int govf, output int gdz,
                         output int glat, output int gbusy, output int gq_after, output int gto);
    int edges;
    gq = 0; grem = 0; govf = 0; gdz = 0; glat = 0; gbusy = 0; gq_after = 0; gto = 1;
    @(negedge clk);
    a = N'(av); b = N'(bv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom);
    edges = 1;
    for (int it = 0; it < 60; it++) begin
      if (busy) gbusy++;
      if (done && glat == 0) begin
        glat = edges; gq = int'(q); grem = int'(rem); govf = int'(ovf); gdz = int'(dz);
      end
      if (glat != 0 && !busy) begin
        gto = 0; gq_after = int'(q);
        break;
      end
      @(negedge clk);
      if (inj_edge == edges + 1) begin start = 1'b1; a = 10'd5; b = 10'd7; end
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, q, rem, ovf, dz} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%0b done=%0b q=%0d rem=%0d ovf=%0b dz=%0b want all 0",
               busy, done, q, rem, ovf, dz);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_exact;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    run_div(96, 64, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (gto !== 0) begin bad++; $display("FAIL exact_timeout got %0d want 0", gto); end
    total++; if (gq !== 48) begin bad++; $display("FAIL exact_q got %0d want 48", gq); end
    total++; if (grem !== 0) begin bad++; $display("FAIL exact_rem got %0d want 0", grem); end
    total++; if ({govf, gdz} !== 0) begin bad++; $display("FAIL exact_flags got ovf=%0d dz=%0d want 0 0", govf, gdz); end
    total++; if (glat !== LAT) begin bad++; $display("FAIL exact_latency got %0d want %0d", glat, LAT); end
    total++; if (gbusy !== LAT) begin bad++; $display("FAIL exact_busy_cycles got %0d want %0d", gbusy, LAT); end
    total++; if (gqa !== 48) begin bad++; $display("FAIL exact_q_held got %0d want 48", gqa); end
  endtask

  task automatic test_rounding;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    run_div(32, 96, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (gq !== 10 + RND) begin bad++; $display("FAIL round_q got %0d want %0d", gq, 10 + RND); end
    total++; if (grem !== 64) begin bad++; $display("FAIL round_rem got %0d want 64", grem); end
    total++; if (govf !== 0) begin bad++; $display("FAIL round_ovf got %0d want 0", govf); end
    total++; if (glat !== 17 + RND) begin bad++; $display("FAIL round_latency got %0d want %0d", glat, 17 + RND); end
  endtask

  task automatic test_overflow;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    run_div(1023, 1, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (gq !== MAXQ) begin bad++; $display("FAIL ovf_q got %0d want %0d", gq, MAXQ); end
    total++; if (govf !== 1) begin bad++; $display("FAIL ovf_flag got %0d want 1", govf); end
    total++; if (gdz !== 0) begin bad++; $display("FAIL ovf_dz got %0d want 0", gdz); end
    total++; if (grem !== 0) begin bad++; $display("FAIL ovf_rem got %0d want 0", grem); end
  endtask

  task automatic test_div_zero;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    run_div(100, 0, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (glat !== 1) begin bad++; $display("FAIL dz_latency got %0d want 1", glat); end
    total++; if (gdz !== 1) begin bad++; $display("FAIL dz_flag got %0d want 1", gdz); end
    total++; if (gq !== MAXQ) begin bad++; $display("FAIL dz_q got %0d want %0d", gq, MAXQ); end
    total++; if ({grem, govf} !== 0) begin bad++; $display("FAIL dz_rem_ovf got rem=%0d ovf=%0d want 0 0", grem, govf); end
    total++; if (gbusy !== 1) begin bad++; $display("FAIL dz_busy_cycles got %0d want 1", gbusy); end
  endtask

  task automatic test_start_while_busy;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    run_div(96, 64, 5, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (gq !== 48) begin bad++; $display("FAIL busy_start_q got %0d want 48", gq); end
    total++; if (glat !== LAT) begin bad++; $display("FAIL busy_start_latency got %0d want %0d", glat, LAT); end
    total++; if (gbusy !== LAT) begin bad++; $display("FAIL busy_start_busy_cycles got %0d want %0d", gbusy, LAT); end
  endtask

  task automatic test_reset_mid;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    @(negedge clk);
    a = 10'd96; b = 10'd64; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, q, rem, ovf, dz} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got busy=%0b done=%0b q=%0d rem=%0d ovf=%0b dz=%0b want all 0",
               busy, done, q, rem, ovf, dz);
    end
    @(negedge clk); rst = 1'b0;
    run_div(32, 96, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
    total++; if (gq !== 10 + RND) begin bad++; $display("FAIL reset_mid_after_q got %0d want %0d", gq, 10 + RND); end
    total++; if (glat !== LAT) begin bad++; $display("FAIL reset_mid_after_latency got %0d want %0d", glat, LAT); end
  endtask

  task automatic test_back_to_back;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    int eq, erem, eovf, edz, elat;
    int ops [3][2] = '{'{500, 3}, '{7, 0}, '{1, 1000}};
    for (int i = 0; i < 3; i++) begin
      run_div(ops[i][0], ops[i][1], 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
      model(ops[i][0], ops[i][1], eq, erem, eovf, edz, elat);
      total++;
      if ({gq, grem, govf, gdz, glat} !== {eq, erem, eovf, edz, elat}) begin
        bad++;
        $display("FAIL b2b_%0d got q=%0d rem=%0d ovf=%0d dz=%0d lat=%0d want q=%0d rem=%0d ovf=%0d dz=%0d lat=%0d",
                 i, gq, grem, govf, gdz, glat, eq, erem, eovf, edz, elat);
      end
    end
  endtask

  task automatic test_random;
    int gq, grem, govf, gdz, glat, gbusy, gqa, gto;
    int eq, erem, eovf, edz, elat;
    int av, bv, sel;
    for (int i = 0; i < 40; i++) begin
      av  = int'($urandom_range(0, MAXQ));
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      bv = 0;
      else if (sel == 1) bv = int'($urandom_range(1, 8));
      else               bv = int'($urandom_range(1, MAXQ));
      run_div(av, bv, 0, gq, grem, govf, gdz, glat, gbusy, gqa, gto);
      model(av, bv, eq, erem, eovf, edz, elat);
      total++;
      if ({gq, grem, govf, gdz, glat, gto} !== {eq, erem, eovf, edz, elat, 0}) begin
        bad++;
        $display("FAIL random_%0d a=%0d b=%0d got q=%0d rem=%0d ovf=%0d dz=%0d lat=%0d to=%0d want q=%0d rem=%0d ovf=%0d dz=%0d lat=%0d",
                 i, av, bv, gq, grem, govf, gdz, glat, gto, eq, erem, eovf, edz, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_rounding();
    test_overflow();
    test_div_zero();
    test_exact();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
